maze_game_ctrl: RTL and testbench
=================================

MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock cycles per one-second tick.
REQ-002 SHALL have parameter TIME_LIMIT, default 120, play-time limit in seconds (used only with MAZE_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_btn  input  1  debounced start-button level.
REQ-006 SHALL have port carve_done  input  1  carver finished level.
REQ-007 SHALL have ports char_x, char_y  input  4 each  player tile position.
REQ-008 SHALL have ports finish_x, finish_y  input  4 each  goal tile position.
REQ-009 SHALL have port carve_start  output  1  one-cycle pulse that launches the carver.
REQ-010 SHALL have port move_en  output  1  player movement enable.
REQ-011 SHALL have port state_o  output  2  current state: IDLE=0, CARVE=1, PLAY=2, WIN=3.
REQ-012 SHALL have port level  output  4  completed-maze count.
REQ-013 SHALL have port win  output  1  high while in WIN.
REQ-014 SHALL have port sec_count  output  10  elapsed play seconds.
REQ-015 SHALL have port timeout  output  1  time-limit-expired flag.

Function
REQ-016 SHALL detect a start_btn rising edge as the registered previous value low and the current value high; a held button SHALL yield one event.
REQ-017 IDLE: on a start event, SHALL go to CARVE, clear sec_count and clear timeout.
REQ-018 SHALL assert carve_start for exactly the first cycle of every CARVE entry.
REQ-019 CARVE: SHALL ignore carve_done until carve_done has been sampled low at least once in this CARVE visit, so a stale done from the previous maze is rejected.
REQ-020 CARVE: on a qualified carve_done high, SHALL go to PLAY on the next edge; start events in CARVE SHALL be ignored.
REQ-021 PLAY: move_en SHALL be 1; move_en SHALL be 0 in all other states (registered, aligned with state_o).
REQ-022 PLAY: the prescaler SHALL count 0..CLK_HZ-1 and wrap; each wrap SHALL increment sec_count, which SHALL saturate at 999.
REQ-023 PLAY: when {char_x,char_y}=={finish_x,finish_y}, SHALL go to WIN and increment level, saturating at 15.
REQ-024 PLAY: a start event without a goal match SHALL abandon the maze, go to CARVE (pulsing carve_start) and leave level unchanged.
REQ-025 If a goal match and a start event occur in the same cycle, the goal match SHALL win.
REQ-026 WIN: win=1 and sec_count frozen; a start event SHALL go to CARVE and clear sec_count.
REQ-027 The prescaler SHALL reset to 0 on every PLAY entry and hold in all other states.
REQ-028 All outputs SHALL be registered, with 1-cycle latency from the causing input to the output.

Reset
REQ-029 Asserting reset SHALL immediately force state_o=IDLE, carve_start=0, move_en=0, level=0, win=0, sec_count=0, timeout=0, prescaler=0 and the edge-detect register to 0.
REQ-030 Reset asserted mid-CARVE or mid-PLAY SHALL abandon the operation with no carve_start pulse on release.

Configuration
REQ-031 With macro MAZE_TIMEOUT_EN defined, reaching sec_count==TIME_LIMIT in PLAY SHALL go to IDLE and set timeout=1 until the next start event.
REQ-032 With MAZE_TIMEOUT_EN undefined, the timeout logic SHALL be absent and the timeout port SHALL be tied to 0.

Structure
REQ-033 Package maze_pkg SHALL hold the state encoding constants, COORD_W=4, SEC_W=10 and LEVEL_MAX=15.
REQ-034 The prescaler SHALL be sub-module maze_sec_tick (inputs clk, reset, run, clear; output tick).

Verification (CLK_HZ=10, TIME_LIMIT=3)
REQ-035 Reset, then a start event: state_o goes 0->1 and carve_start is high for exactly 1 cycle; carve_done held high throughout never reaches PLAY until it drops low and rises again.
REQ-036 In PLAY, hold char=(2,3), finish=(15,15) for 25 cycles -> sec_count=2; then set char=(15,15) -> state_o=3, win=1, level=1 on the next edge.
REQ-037 Goal match and start rise in the same cycle -> state_o=3 and level increments; no carve_start.
REQ-038 Start held high for 50 cycles in IDLE -> exactly one carve_start pulse.
REQ-039 With MAZE_TIMEOUT_EN defined, 30 PLAY cycles with no goal match -> state_o=0, timeout=1; next start event clears timeout. Without the macro -> still PLAY, timeout=0.
REQ-040 Reset asserted mid-PLAY with sec_count=2 -> all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants and state encoding for the maze game controller.
package maze_pkg;

  localparam int COORD_W = 4;
  localparam int SEC_W   = 10;
  localparam int LEVEL_W = 4;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;
  localparam logic [SEC_W-1:0]   SEC_MAX   = 10'd999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CARVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

endpackage

// File: rtl/maze_sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 while run is high, pulses tick on wrap.
module maze_sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // tick is combinational off the registered count so the seconds counter
  // advances on the same edge the prescaler wraps.
  assign w_wrap = run && !clear && (r_cnt == CNT_LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: IDLE -> CARVE -> PLAY -> WIN, with level and play-time tracking.
// Optional play-time limit enabled by defining MAZE_TIMEOUT_EN.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               carve_done,
  input  logic [COORD_W-1:0] char_x,
  input  logic [COORD_W-1:0] char_y,
  input  logic [COORD_W-1:0] finish_x,
  input  logic [COORD_W-1:0] finish_y,
  output logic               carve_start,
  output logic               move_en,
  output logic [1:0]         state_o,
  output logic [LEVEL_W-1:0] level,
  output logic               win,
  output logic [SEC_W-1:0]   sec_count,
  output logic               timeout
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_btn_prev;
  logic               r_done_low_seen;
  logic               r_carve_start;
  logic               r_move_en;
  logic               r_win;
  logic [LEVEL_W-1:0] r_level;
  logic [SEC_W-1:0]   r_sec;

  logic               w_start_evt;
  logic               w_goal;
  logic               w_done_ok;
  logic               w_tick;
  logic               w_time_up;
  logic               w_enter_carve;
  logic               w_enter_play;
  logic               w_done_seen_next;
  logic               w_carve_start_next;
  logic               w_move_en_next;
  logic               w_win_next;
  logic [LEVEL_W-1:0] w_level_next;
  logic [SEC_W-1:0]   w_sec_next;

  assign w_start_evt = start_btn && !r_btn_prev;
  assign w_goal      = ({char_x, char_y} == {finish_x, finish_y});
  // A done level left over from the previous maze must drop before it counts.
  assign w_done_ok   = r_done_low_seen && carve_done;

  assign w_enter_carve = (w_state_next == ST_CARVE) && (r_state != ST_CARVE);
  assign w_enter_play  = (w_state_next == ST_PLAY) && (r_state != ST_PLAY);

  maze_sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .run   (r_state == ST_PLAY),
    .clear (w_enter_play),
    .tick  (w_tick)
  );

`ifdef MAZE_TIMEOUT_EN
  localparam logic [SEC_W-1:0] SEC_LIMIT_M1 = SEC_W'(TIME_LIMIT - 1);

  logic r_timeout;

  // Leave PLAY on the same edge the seconds counter reaches the limit.
  assign w_time_up = (r_state == ST_PLAY) && w_tick && (r_sec == SEC_LIMIT_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_time_up) begin
      r_timeout <= 1'b1;
    end else if (w_enter_carve) begin
      r_timeout <= 1'b0;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_limit;

  assign w_unused_limit = (TIME_LIMIT > 0);
  assign w_time_up      = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_btn_prev      <= 1'b0;
      r_done_low_seen <= 1'b0;
      r_carve_start   <= 1'b0;
      r_move_en       <= 1'b0;
      r_win           <= 1'b0;
      r_level         <= '0;
      r_sec           <= '0;
    end else begin
      r_state         <= w_state_next;
      r_btn_prev      <= start_btn;
      r_done_low_seen <= w_done_seen_next;
      r_carve_start   <= w_carve_start_next;
      r_move_en       <= w_move_en_next;
      r_win           <= w_win_next;
      r_level         <= w_level_next;
      r_sec           <= w_sec_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_evt) w_state_next = ST_CARVE;
      end
      ST_CARVE: begin
        if (w_done_ok) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_goal)           w_state_next = ST_WIN;
        else if (w_time_up)   w_state_next = ST_IDLE;
        else if (w_start_evt) w_state_next = ST_CARVE;
      end
      ST_WIN: begin
        if (w_start_evt) w_state_next = ST_CARVE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_carve_start_next = w_enter_carve;
    w_move_en_next     = (w_state_next == ST_PLAY);
    w_win_next         = (w_state_next == ST_WIN);

    w_done_seen_next = r_done_low_seen;
    if (w_enter_carve) begin
      w_done_seen_next = 1'b0;
    end else if ((r_state == ST_CARVE) && !carve_done) begin
      w_done_seen_next = 1'b1;
    end

    w_level_next = r_level;
    if ((r_state == ST_PLAY) && (w_state_next == ST_WIN) && (r_level != LEVEL_MAX)) begin
      w_level_next = r_level + 1'b1;
    end

    w_sec_next = r_sec;
    if (w_enter_carve) begin
      w_sec_next = '0;
    end else if ((r_state == ST_PLAY) && w_tick && (r_sec != SEC_MAX)) begin
      w_sec_next = r_sec + 1'b1;
    end
  end

  assign carve_start = r_carve_start;
  assign move_en     = r_move_en;
  assign state_o     = r_state;
  assign level       = r_level;
  assign win         = r_win;
  assign sec_count   = r_sec;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl (CLK_HZ=10, TIME_LIMIT=3).
module tb_maze_game_ctrl;

  localparam int S_STATE = 0;
  localparam int S_CS    = 1;
  localparam int S_MOVE  = 2;
  localparam int S_LEVEL = 3;
  localparam int S_WIN   = 4;
  localparam int S_SEC   = 5;
  localparam int S_TO    = 6;

`ifdef MAZE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       carve_done = 1'b1;
  logic [3:0] char_x = 4'd2;
  logic [3:0] char_y = 4'd3;
  logic [3:0] finish_x = 4'd15;
  logic [3:0] finish_y = 4'd15;
  logic       carve_start;
  logic       move_en;
  logic [1:0] state_o;
  logic [3:0] level;
  logic       win;
  logic [9:0] sec_count;
  logic       timeout;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pulses = 0;

  maze_game_ctrl #(
    .CLK_HZ     (10),
    .TIME_LIMIT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .carve_done  (carve_done),
    .char_x      (char_x),
    .char_y      (char_y),
    .finish_x    (finish_x),
    .finish_y    (finish_y),
    .carve_start (carve_start),
    .move_en     (move_en),
    .state_o     (state_o),
    .level       (level),
    .win         (win),
    .sec_count   (sec_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (carve_start === 1'b1) n_pulses++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_STATE: return int'(state_o);
      S_CS:    return int'(carve_start);
      S_MOVE:  return int'(move_en);
      S_LEVEL: return int'(level);
      S_WIN:   return int'(win);
      S_SEC:   return int'(sec_count);
      default: return int'(timeout);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Expectations pushed before a step describe outputs after the next edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_state"}, observe(S_STATE), 0);
    check_val({pfx, "_cs"},    observe(S_CS), 0);
    check_val({pfx, "_move"},  observe(S_MOVE), 0);
    check_val({pfx, "_level"}, observe(S_LEVEL), 0);
    check_val({pfx, "_win"},   observe(S_WIN), 0);
    check_val({pfx, "_sec"},   observe(S_SEC), 0);
    check_val({pfx, "_to"},    observe(S_TO), 0);
  endtask

  // From CARVE with carve_done high: drop then raise done to reach PLAY.
  task automatic carve_to_play(input string tag);
    carve_done = 1'b0;
    push({tag, "_lo"}, S_STATE, 1);
    step();
    carve_done = 1'b1;
    push({tag, "_play"}, S_STATE, 2);
    push({tag, "_move"}, S_MOVE, 1);
    step();
  endtask

  initial begin
    int p0;

    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    $display("txn reset: outputs at reset values");
    reset = 1'b0;
    push("idle", S_STATE, 0);
    step();

    // Start event, stale carve_done, ignored start events in CARVE.
    start_btn = 1'b1;
    push("carve_entry", S_STATE, 1);
    push("carve_pulse", S_CS, 1);
    push("carve_move", S_MOVE, 0);
    step();
    push("carve_hold", S_STATE, 1);
    push("carve_pulse_end", S_CS, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      start_btn = (i % 2 == 1);
      push("stale_done", S_STATE, 1);
      push("stale_cs", S_CS, 0);
      step();
    end
    carve_to_play("first");
    $display("txn carve: reached PLAY after done low/high");

    for (int k = 1; k <= 25; k++) begin
      push("play_state", S_STATE, 2);
      push("play_sec", S_SEC, k / 10);
      step();
    end
    char_x = 4'd15;
    char_y = 4'd15;
    push("win_state", S_STATE, 3);
    push("win_flag", S_WIN, 1);
    push("win_level", S_LEVEL, 1);
    push("win_move", S_MOVE, 0);
    push("win_sec", S_SEC, 2);
    step();
    for (int i = 0; i < 2; i++) begin
      push("win_frozen_sec", S_SEC, 2);
      push("win_hold", S_STATE, 3);
      step();
    end
    $display("txn goal: WIN level=%0d sec=%0d", level, sec_count);

    // Restart from WIN, then goal and start in the same cycle.
    start_btn = 1'b0;
    char_x = 4'd2;
    char_y = 4'd3;
    push("win_idle_btn", S_STATE, 3);
    step();
    start_btn = 1'b1;
    push("restart_state", S_STATE, 1);
    push("restart_cs", S_CS, 1);
    push("restart_sec", S_SEC, 0);
    push("restart_win", S_WIN, 0);
    push("restart_level", S_LEVEL, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      push("restart_stale", S_STATE, 1);
      step();
    end
    carve_to_play("second");
    start_btn = 1'b0;
    push("second_play", S_STATE, 2);
    step();
    start_btn = 1'b1;
    char_x = 4'd15;
    char_y = 4'd15;
    push("tie_state", S_STATE, 3);
    push("tie_level", S_LEVEL, 2);
    push("tie_cs", S_CS, 0);
    step();
    push("tie_cs_after", S_CS, 0);
    push("tie_hold", S_STATE, 3);
    step();
    $display("txn tie: goal beat start, level=%0d", level);

    // Abandon a maze from PLAY.
    start_btn = 1'b0;
    char_x = 4'd2;
    char_y = 4'd3;
    push("pre_abandon", S_STATE, 3);
    step();
    start_btn = 1'b1;
    push("abandon_c1", S_STATE, 1);
    step();
    carve_to_play("abandon");
    start_btn = 1'b0;
    push("abandon_play", S_STATE, 2);
    step();
    start_btn = 1'b1;
    push("abandon_state", S_STATE, 1);
    push("abandon_cs", S_CS, 1);
    push("abandon_level", S_LEVEL, 2);
    push("abandon_move", S_MOVE, 0);
    step();
    $display("txn abandon: back to CARVE, level=%0d", level);

    // Play-time limit.
    carve_to_play("limit");
    for (int k = 1; k <= 30; k++) begin
      if (k < 30) begin
        push("limit_play", S_STATE, 2);
        push("limit_sec", S_SEC, k / 10);
      end else begin
        push("limit_state", S_STATE, TO_EN ? 0 : 2);
        push("limit_to", S_TO, TO_EN ? 1 : 0);
        push("limit_sec_end", S_SEC, 3);
      end
      step();
    end
    start_btn = 1'b0;
    push("limit_to_hold", S_TO, TO_EN ? 1 : 0);
    step();
    start_btn = 1'b1;
    push("limit_restart", S_STATE, 1);
    push("limit_to_clear", S_TO, 0);
    push("limit_cs", S_CS, 1);
    step();
    $display("txn limit: timeout path done (enabled=%0d)", TO_EN);

    // Asynchronous reset mid-PLAY.
    carve_to_play("midrst");
    for (int k = 1; k <= 20; k++) begin
      push("midrst_sec", S_SEC, k / 10);
      step();
    end
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    start_btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push("post_rst_state", S_STATE, 0);
    push("post_rst_cs", S_CS, 0);
    step();
    $display("txn midrst: async reset cleared outputs");

    // Held button in IDLE gives a single launch.
    p0 = n_pulses;
    start_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      push("held_state", S_STATE, 1);
      step();
    end
    check_val("held_pulses", n_pulses - p0, 1);
    $display("txn held: pulses=%0d", n_pulses - p0);

    // Level saturation.
    char_x = 4'd15;
    char_y = 4'd15;
    for (int i = 1; i <= 16; i++) begin
      carve_done = 1'b0;
      push("sat_lo", S_STATE, 1);
      step();
      carve_done = 1'b1;
      push("sat_play", S_STATE, 2);
      step();
      push("sat_win", S_STATE, 3);
      push("sat_level", S_LEVEL, (i > 15) ? 15 : i);
      step();
      start_btn = 1'b0;
      step();
      start_btn = 1'b1;
      push("sat_carve", S_STATE, 1);
      step();
      $display("txn sat: win %0d level=%0d", i, level);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
